// File: rtl/fm_wm_aggregation_reader.sv
// Walks a destination-sorted edge list and sums product-memory rows per destination.
// Two cycles per edge, row emitted two cycles after the group's last edge; edge stream stalls outside WAIT_EDGE.
module fm_wm_aggregation_reader #(
   parameter int NUM_NODES      = 6,
   parameter int WEIGHT_COLS    = 3,
   parameter int DOT_PROD_WIDTH = 16,
   parameter int ACC_WIDTH      = 20,
   parameter int ROW_AW         = 3
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic                                      start,
   input  logic                                      edge_valid,
   output logic                                      edge_ready,
   input  logic [ROW_AW-1:0]                         edge_src,
   input  logic [ROW_AW-1:0]                         edge_dst,
   input  logic                                      edge_dst_last,
   input  logic                                      edge_last,
   output logic [ROW_AW-1:0]                         read_row,
   input  logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] fm_wm_row_in,
   output logic                                      agg_valid,
   input  logic                                      agg_ready,
   output logic [ROW_AW-1:0]                         agg_node,
   output logic [WEIGHT_COLS-1:0][ACC_WIDTH-1:0]     agg_row,
   output logic                                      busy,
   output logic                                      done,
   output logic                                      err_src
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_EDGE,
      S_ACCUM,
      S_EMIT,
      S_DONE
   } state_t;

   localparam int SUM_W = ACC_WIDTH + 1;
   localparam logic [ROW_AW:0] NUM_NODES_W = (ROW_AW+1)'(NUM_NODES);

   state_t                                state_q, state_d;
   logic [ROW_AW-1:0]                     read_row_q, read_row_d;
   logic [ROW_AW-1:0]                     src_q, src_d;
   logic [ROW_AW-1:0]                     dst_q, dst_d;
   logic                                  dst_last_q, dst_last_d;
   logic                                  last_q, last_d;
   logic                                  grp_first_q, grp_first_d;
   logic [WEIGHT_COLS-1:0][ACC_WIDTH-1:0] acc_q, acc_d;
   logic [WEIGHT_COLS-1:0][ACC_WIDTH-1:0] agg_row_q, agg_row_d;
   logic [ROW_AW-1:0]                     agg_node_q, agg_node_d;
   logic                                  err_src_q, err_src_d;

   logic                                  src_in_range;
   logic [WEIGHT_COLS-1:0][SUM_W-1:0]     sum_w;
   logic [WEIGHT_COLS-1:0][ACC_WIDTH-1:0] acc_sat;

   assign src_in_range = ({1'b0, src_q} < NUM_NODES_W);

   // One spare bit per element catches overflow so the element clamps instead of wrapping.
   always_comb begin
      sum_w   = '0;
      acc_sat = '0;
      for (int c = 0; c < WEIGHT_COLS; c++) begin
         sum_w[c] = {1'b0, acc_q[c]}
                  + (src_in_range ? SUM_W'(fm_wm_row_in[c]) : SUM_W'(0));
         acc_sat[c] = sum_w[c][ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum_w[c][ACC_WIDTH-1:0];
      end
   end

   always_comb begin
      state_d     = state_q;
      read_row_d  = read_row_q;
      src_d       = src_q;
      dst_d       = dst_q;
      dst_last_d  = dst_last_q;
      last_d      = last_q;
      grp_first_d = grp_first_q;
      acc_d       = acc_q;
      agg_row_d   = agg_row_q;
      agg_node_d  = agg_node_q;
      err_src_d   = err_src_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_WAIT_EDGE;
               acc_d       = '0;
               err_src_d   = 1'b0;
               grp_first_d = 1'b1;
            end
         end
         S_WAIT_EDGE: begin
            if (edge_valid) begin
               src_d      = edge_src;
               read_row_d = edge_src;
               dst_last_d = edge_dst_last | edge_last;
               last_d     = edge_last;
               // A group keeps the destination of its first edge.
               if (grp_first_q) begin
                  dst_d = edge_dst;
               end
               grp_first_d = 1'b0;
               state_d     = S_ACCUM;
            end
         end
         S_ACCUM: begin
            acc_d = acc_sat;
            if (!src_in_range) begin
               err_src_d = 1'b1;
            end
            if (dst_last_q) begin
               agg_row_d  = acc_sat;
               agg_node_d = dst_q;
               state_d    = S_EMIT;
            end else begin
               state_d = S_WAIT_EDGE;
            end
         end
         S_EMIT: begin
            if (agg_ready) begin
               acc_d       = '0;
               grp_first_d = 1'b1;
               state_d     = last_q ? S_DONE : S_WAIT_EDGE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         read_row_q  <= '0;
         src_q       <= '0;
         dst_q       <= '0;
         dst_last_q  <= 1'b0;
         last_q      <= 1'b0;
         grp_first_q <= 1'b0;
         acc_q       <= '0;
         agg_row_q   <= '0;
         agg_node_q  <= '0;
         err_src_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         read_row_q  <= read_row_d;
         src_q       <= src_d;
         dst_q       <= dst_d;
         dst_last_q  <= dst_last_d;
         last_q      <= last_d;
         grp_first_q <= grp_first_d;
         acc_q       <= acc_d;
         agg_row_q   <= agg_row_d;
         agg_node_q  <= agg_node_d;
         err_src_q   <= err_src_d;
      end
   end

   assign edge_ready = (state_q == S_WAIT_EDGE);
   assign agg_valid  = (state_q == S_EMIT);
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);
   assign read_row   = read_row_q;
   assign agg_node   = agg_node_q;
   assign agg_row    = agg_row_q;
   assign err_src    = err_src_q;

endmodule

// File: tb/tb_fm_wm_aggregation_reader.sv
// Directed bench for fm_wm_aggregation_reader with a behavioural product memory.
module tb_fm_wm_aggregation_reader;

   localparam int NN = 6;
   localparam int WC = 3;
   localparam int DW = 16;
   localparam int AW = 20;
   localparam int RA = 3;

   typedef logic [WC-1:0][AW-1:0] acc_row_t;
   typedef logic [WC-1:0][DW-1:0] prod_row_t;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic            edge_valid;
   logic            edge_ready;
   logic [RA-1:0]   edge_src;
   logic [RA-1:0]   edge_dst;
   logic            edge_dst_last;
   logic            edge_last;
   logic [RA-1:0]   read_row;
   prod_row_t       fm_wm_row_in;
   logic            agg_valid;
   logic            agg_ready;
   logic [RA-1:0]   agg_node;
   acc_row_t        agg_row;
   logic            busy;
   logic            done;
   logic            err_src;

   prod_row_t mem [8];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   assign fm_wm_row_in = mem[read_row];

   fm_wm_aggregation_reader #(
      .NUM_NODES(NN), .WEIGHT_COLS(WC), .DOT_PROD_WIDTH(DW), .ACC_WIDTH(AW), .ROW_AW(RA)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .edge_valid(edge_valid), .edge_ready(edge_ready),
      .edge_src(edge_src), .edge_dst(edge_dst),
      .edge_dst_last(edge_dst_last), .edge_last(edge_last),
      .read_row(read_row), .fm_wm_row_in(fm_wm_row_in),
      .agg_valid(agg_valid), .agg_ready(agg_ready),
      .agg_node(agg_node), .agg_row(agg_row),
      .busy(busy), .done(done), .err_src(err_src)
   );

   function automatic acc_row_t mkrow(input int a, input int b, input int c);
      acc_row_t r;
      r[0] = AW'(a);
      r[1] = AW'(b);
      r[2] = AW'(c);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Returns with the edge accepted and the DUT one cycle past the handshake.
   task automatic send_edge(input int src, input int dst, input bit dl, input bit lst,
                            output bit ok);
      ok            = 1'b0;
      edge_valid    = 1'b1;
      edge_src      = RA'(src);
      edge_dst      = RA'(dst);
      edge_dst_last = dl;
      edge_last     = lst;
      for (int i = 0; i < 40; i++) begin
         if (edge_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (ok) tick();
      edge_valid    = 1'b0;
      edge_dst_last = 1'b0;
      edge_last     = 1'b0;
   endtask

   task automatic wait_agg(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (agg_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic handshake();
      agg_ready = 1'b1;
      tick();
      agg_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (edge_ready !== 1'b0) begin errors++; $display("FAIL reset_edge_ready: got %b want 0", edge_ready); end
      checks++; if (agg_valid !== 1'b0) begin errors++; $display("FAIL reset_agg_valid: got %b want 0", agg_valid); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (err_src !== 1'b0) begin errors++; $display("FAIL reset_err_src: got %b want 0", err_src); end
      checks++; if (read_row !== 3'd0) begin errors++; $display("FAIL reset_read_row: got %0d want 0", read_row); end
      checks++; if (agg_node !== 3'd0) begin errors++; $display("FAIL reset_agg_node: got %0d want 0", agg_node); end
      checks++; if (agg_row !== acc_row_t'(0)) begin errors++; $display("FAIL reset_agg_row: got %h want 0", agg_row); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_two_groups();
      bit ok;
      pulse_start();
      checks++; if (busy !== 1'b1 || edge_ready !== 1'b1) begin errors++; $display("FAIL t1_wait: busy=%b edge_ready=%b want 1 1", busy, edge_ready); end
      send_edge(1, 0, 1'b1, 1'b0, ok);
      wait_agg(ok);
      checks++; if (!ok) begin errors++; $display("FAIL t1_agg_a_timeout: agg_valid=%b want 1", agg_valid); end
      checks++; if (agg_node !== 3'd0 || agg_row !== mkrow(1, 2, 3)) begin errors++; $display("FAIL t1_agg_a: node=%0d row=%h want node=0 row=%h", agg_node, agg_row, mkrow(1, 2, 3)); end
      handshake();
      send_edge(2, 0, 1'b0, 1'b0, ok);
      send_edge(3, 0, 1'b1, 1'b1, ok);
      wait_agg(ok);
      checks++; if (!ok) begin errors++; $display("FAIL t1_agg_b_timeout: agg_valid=%b want 1", agg_valid); end
      checks++; if (agg_node !== 3'd0 || agg_row !== mkrow(110, 220, 330)) begin errors++; $display("FAIL t1_agg_b: node=%0d row=%h want node=0 row=%h", agg_node, agg_row, mkrow(110, 220, 330)); end
      handshake();
      checks++; if (done !== 1'b1 || agg_valid !== 1'b0) begin errors++; $display("FAIL t1_done: done=%b agg_valid=%b want 1 0", done, agg_valid); end
      tick();
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t1_idle: done=%b busy=%b want 0 0", done, busy); end
      checks++; if (agg_row !== mkrow(110, 220, 330)) begin errors++; $display("FAIL t1_hold_row: got %h want %h", agg_row, mkrow(110, 220, 330)); end
   endtask

   task automatic test_single_latency();
      bit ok;
      pulse_start();
      send_edge(4, 5, 1'b1, 1'b1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL t2_edge_timeout: edge_ready=%b want 1", edge_ready); end
      checks++; if (agg_valid !== 1'b0 || read_row !== 3'd4) begin errors++; $display("FAIL t2_accum: agg_valid=%b read_row=%0d want 0 4", agg_valid, read_row); end
      tick();
      checks++; if (agg_valid !== 1'b1) begin errors++; $display("FAIL t2_latency: agg_valid=%b want 1", agg_valid); end
      checks++; if (agg_node !== 3'd5 || agg_row !== mkrow(7, 8, 9)) begin errors++; $display("FAIL t2_row: node=%0d row=%h want node=5 row=%h", agg_node, agg_row, mkrow(7, 8, 9)); end
      handshake();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL t2_done: got %b want 1", done); end
      tick();
   endtask

   task automatic test_saturation();
      bit ok;
      pulse_start();
      for (int i = 0; i < 20; i++) begin
         send_edge(5, 3, (i == 19), (i == 19), ok);
      end
      wait_agg(ok);
      checks++; if (!ok) begin errors++; $display("FAIL t3_timeout: agg_valid=%b want 1", agg_valid); end
      checks++; if (agg_row[0] !== 20'd1048575) begin errors++; $display("FAIL t3_sat0: got %0d want 1048575", agg_row[0]); end
      checks++; if (agg_row[1] !== 20'd0) begin errors++; $display("FAIL t3_elem1: got %0d want 0", agg_row[1]); end
      checks++; if (agg_row[2] !== 20'd20) begin errors++; $display("FAIL t3_elem2: got %0d want 20", agg_row[2]); end
      checks++; if (agg_node !== 3'd3) begin errors++; $display("FAIL t3_node: got %0d want 3", agg_node); end
      handshake();
      tick();
   endtask

   task automatic test_backpressure();
      bit ok;
      pulse_start();
      send_edge(1, 2, 1'b1, 1'b1, ok);
      wait_agg(ok);
      edge_valid = 1'b1;
      edge_src   = 3'd3;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (agg_valid !== 1'b1 || edge_ready !== 1'b0 || agg_row !== mkrow(1, 2, 3) || agg_node !== 3'd2) begin
            errors++;
            $display("FAIL t4_stall%0d: agg_valid=%b edge_ready=%b node=%0d row=%h want 1 0 2 %h",
                     i, agg_valid, edge_ready, agg_node, agg_row, mkrow(1, 2, 3));
         end
         tick();
      end
      edge_valid = 1'b0;
      handshake();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL t4_release: done=%b want 1", done); end
      tick();
   endtask

   task automatic test_bad_src();
      bit ok;
      pulse_start();
      send_edge(7, 1, 1'b0, 1'b0, ok);
      send_edge(0, 1, 1'b1, 1'b1, ok);
      wait_agg(ok);
      checks++; if (agg_row !== mkrow(5, 5, 5) || agg_node !== 3'd1) begin errors++; $display("FAIL t5_row: node=%0d row=%h want 1 %h", agg_node, agg_row, mkrow(5, 5, 5)); end
      checks++; if (err_src !== 1'b1) begin errors++; $display("FAIL t5_err_set: got %b want 1", err_src); end
      handshake();
      tick();
      checks++; if (err_src !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL t5_err_sticky: err=%b busy=%b want 1 0", err_src, busy); end
      pulse_start();
      checks++; if (err_src !== 1'b0) begin errors++; $display("FAIL t5_err_clear: got %b want 0", err_src); end
   endtask

   // Continues from the walk left open by test_bad_src.
   task automatic test_reset_mid_walk();
      bit ok;
      bit seen;
      send_edge(1, 2, 1'b0, 1'b0, ok);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (busy !== 1'b0 || edge_ready !== 1'b0 || agg_valid !== 1'b0) begin errors++; $display("FAIL t6_idle: busy=%b edge_ready=%b agg_valid=%b want 0 0 0", busy, edge_ready, agg_valid); end
      checks++; if (agg_row !== acc_row_t'(0) || agg_node !== 3'd0 || read_row !== 3'd0) begin errors++; $display("FAIL t6_zero: row=%h node=%0d read_row=%0d want 0 0 0", agg_row, agg_node, read_row); end
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (agg_valid !== 1'b0 || done !== 1'b0) seen = 1'b1;
         tick();
      end
      checks++; if (seen) begin errors++; $display("FAIL t6_no_emit: spurious agg_valid/done got 1 want 0"); end
      pulse_start();
      send_edge(3, 4, 1'b1, 1'b1, ok);
      wait_agg(ok);
      checks++; if (!ok) begin errors++; $display("FAIL t6_restart_timeout: agg_valid=%b want 1", agg_valid); end
      checks++; if (agg_node !== 3'd4 || agg_row !== mkrow(100, 200, 300)) begin errors++; $display("FAIL t6_restart: node=%0d row=%h want 4 %h", agg_node, agg_row, mkrow(100, 200, 300)); end
      handshake();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL t6_done: got %b want 1", done); end
      tick();
   endtask

   initial begin
      mem[0] = {16'd5, 16'd5, 16'd5};
      mem[1] = {16'd3, 16'd2, 16'd1};
      mem[2] = {16'd30, 16'd20, 16'd10};
      mem[3] = {16'd300, 16'd200, 16'd100};
      mem[4] = {16'd9, 16'd8, 16'd7};
      mem[5] = {16'd1, 16'd0, 16'd65535};
      mem[6] = {16'd11, 16'd11, 16'd11};
      mem[7] = {16'd99, 16'd99, 16'd99};
      reset         = 1'b1;
      start         = 1'b0;
      edge_valid    = 1'b0;
      edge_src      = '0;
      edge_dst      = '0;
      edge_dst_last = 1'b0;
      edge_last     = 1'b0;
      agg_ready     = 1'b0;

      test_reset();
      test_two_groups();
      test_single_latency();
      test_saturation();
      test_backpressure();
      test_bad_src();
      test_reset_mid_walk();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
